// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  localparam logic [7:0]  TAG_BASE_DEF  = 8'hF0;
  localparam int unsigned MAX_BURST_DEF = 64;
  localparam int unsigned IDLE_TMO_DEF  = 1023;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_TAG,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams plus the TX engine handshake, shared by arbiter and environment.
interface uart_tx_arb_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_byte;
  logic               tx_req;
  logic               tx_idle;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    input  req_valid, req_data, req_last, tx_idle,
    output req_ready, tx_byte, tx_req, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, tx_idle,
    input  req_ready, tx_byte, tx_req, grant_id, busy
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned GW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last,
  output logic             found,
  output logic [GW-1:0]    winner
);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!found && req[(32'(last) + i) % N_REQ]) begin
        found  = 1'b1;
        winner = GW'((32'(last) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX engine among N_REQ byte streams,
// keeping each granted message contiguous and optionally prefixing a tag byte.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ID_PREFIX = 1,
  parameter logic [7:0]  TAG_BASE  = TAG_BASE_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned IDLE_TMO  = IDLE_TMO_DEF
) (
  input  logic           fpga_sysclk,
  input  logic           rst_fpga_,
  uart_tx_arb_if.master  bus
);

  localparam int unsigned GW = $clog2(N_REQ);

  state_t           state;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    last_grant;
  logic [7:0]       cnt;
  logic [15:0]      tmo;
  logic [7:0]       tx_byte_q;
  logic             is_tag;
  logic             last_cap;

  logic             found;
  logic [GW-1:0]    winner;
  logic [7:0]       sel_data;
  logic [N_REQ-1:0] ready;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req_valid),
    .last   (last_grant),
    .found  (found),
    .winner (winner)
  );

  assign sel_data = bus.req_data[8*int'(grant_q) +: 8];

  always_comb begin
    ready = '0;
    if (state == ST_LOAD) ready[grant_q] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.tx_req    = (state == ST_SEND) && bus.tx_idle;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state != ST_ARB);

  always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
    if (!rst_fpga_) begin
      state      <= ST_ARB;
      grant_q    <= '0;
      last_grant <= GW'(N_REQ - 1);
      cnt        <= '0;
      tmo        <= '0;
      tx_byte_q  <= '0;
      is_tag     <= 1'b0;
      last_cap   <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (found) begin
            grant_q    <= winner;
            last_grant <= winner;
            cnt        <= '0;
            tmo        <= '0;
            state      <= (ID_PREFIX != 0) ? ST_TAG : ST_LOAD;
          end
        end
        ST_TAG: begin
          tx_byte_q <= TAG_BASE | 8'(grant_q);
          is_tag    <= 1'b1;
          state     <= ST_SEND;
        end
        ST_LOAD: begin
          if (bus.req_valid[grant_q]) begin
            tx_byte_q <= sel_data;
            last_cap  <= bus.req_last[grant_q];
            cnt       <= cnt + 8'd1;
            state     <= ST_SEND;
          end else if (tmo == 16'(IDLE_TMO)) begin
            state <= ST_ARB;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        ST_SEND: begin
          if (bus.tx_idle) state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!bus.tx_idle) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.tx_idle) begin
            // A forced release leaves the message open; the next grant re-tags it.
            if (is_tag) begin
              is_tag <= 1'b0;
              state  <= ST_LOAD;
            end else if (last_cap || cnt == 8'(MAX_BURST)) begin
              state <= ST_ARB;
            end else begin
              tmo   <= '0;
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: table of message mixes with expected wire order,
// plus hand sequences for latency, idle timeout and reset in mid-message.
module tb_uart_tx_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(4)) bus ();

  uart_tx_arb #(
    .N_REQ     (4),
    .ID_PREFIX (1),
    .TAG_BASE  (8'hF0),
    .MAX_BURST (4),
    .IDLE_TMO  (20)
  ) dut (
    .fpga_sysclk (clk),
    .rst_fpga_   (rst_n),
    .bus         (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // requester sources
  logic [8:0] sbuf [4][16];
  int         wr [4];
  int         rd [4];
  int         rdy_cnt [4];
  logic [3:0] pause;
  int         hold_len;

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (!rst_n) begin
        rd[r]      <= 0;
        rdy_cnt[r] <= 0;
      end else if (bus.req_valid[r] && bus.req_ready[r]) begin
        rd[r]      <= rd[r] + 1;
        rdy_cnt[r] <= rdy_cnt[r] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int r = 0; r < 4; r++) begin
      bus.req_valid[r]      = (rd[r] < wr[r]) && !pause[r];
      bus.req_data[8*r +: 8] = sbuf[r][rd[r] & 15][7:0];
      bus.req_last[r]       = sbuf[r][rd[r] & 15][8];
    end
  end

  // TX engine model: goes busy for hold_len cycles after each tx_req
  logic [7:0] wire_q [$];
  int         hold;
  logic [7:0] inflight;
  int         txreq_cnt;
  int         req_while_busy = 0;
  int         unstable = 0;
  int         bad_ready = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.tx_idle <= 1'b1;
      hold        <= 0;
      txreq_cnt   <= 0;
      wire_q.delete();
    end else begin
      if ((bus.req_ready & ~(4'b0001 << bus.grant_id)) != 4'b0000)
        bad_ready <= bad_ready + 1;
      if (bus.tx_req) begin
        if (!bus.tx_idle) req_while_busy <= req_while_busy + 1;
        wire_q.push_back(bus.tx_byte);
        inflight    <= bus.tx_byte;
        txreq_cnt   <= txreq_cnt + 1;
        bus.tx_idle <= 1'b0;
        hold        <= hold_len;
      end else if (hold > 0) begin
        if (bus.tx_byte != inflight) unstable <= unstable + 1;
        if (hold == 1) bus.tx_idle <= 1'b1;
        hold <= hold - 1;
      end
    end
  end

  task automatic push(input int r, input int n, input logic [7:0] d0);
    for (int k = 0; k < n; k++) begin
      sbuf[r][wr[r]] = {(k == n - 1), 8'(d0 + 8'(k))};
      wr[r]++;
    end
  endtask

  task automatic rst_begin();
    @(negedge clk);
    rst_n = 1'b0;
    pause = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) wr[r] = 0;
  endtask

  task automatic rst_end();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int quiet = 0;
    int cyc = 0;
    bit empty;
    while (quiet < 4 && cyc < bound) begin
      @(posedge clk);
      #1;
      cyc++;
      empty = 1'b1;
      for (int r = 0; r < 4; r++) if (rd[r] < wr[r]) empty = 1'b0;
      if (empty && !bus.busy && bus.tx_idle) quiet++;
      else quiet = 0;
    end
    chk({nm, "_done"}, int'(quiet >= 4), 1);
  endtask

  task automatic check_wire(input string nm, input logic [0:15][7:0] e, input int len);
    chk({nm, "_len"}, wire_q.size(), len);
    for (int i = 0; i < len; i++)
      chk($sformatf("%s_b%0d", nm, i), (i < wire_q.size()) ? int'(wire_q[i]) : -1, int'(e[i]));
  endtask

  typedef struct packed {
    logic [7:0]        hold;
    logic [0:3][7:0]   nb;
    logic [0:3][7:0]   d0;
    logic [7:0]        len;
    logic [0:15][7:0]  exp;
  } vec_t;

  function automatic vec_t mk(input int hold, input logic [0:3][7:0] nb,
                              input logic [0:3][7:0] d0, input int len,
                              input logic [127:0] e);
    vec_t v;
    v.hold = 8'(hold);
    v.nb   = nb;
    v.d0   = d0;
    v.len  = 8'(len);
    v.exp  = e << (8 * (16 - len));
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int cyc;
    int n0;
    logic [0:15][7:0] e;

    vecs[0] = mk(3,  {8'd0, 8'd0, 8'd2, 8'd0},  {8'h00, 8'h00, 8'h41, 8'h00}, 3,
                 24'hF2_41_42);
    vecs[1] = mk(3,  {8'd3, 8'd3, 8'd0, 8'd3},  {8'h10, 8'h20, 8'h00, 8'h30}, 12,
                 96'hF0_10_11_12_F1_20_21_22_F3_30_31_32);
    vecs[2] = mk(2,  {8'd0, 8'd10, 8'd2, 8'd0}, {8'h00, 8'hA0, 8'hB0, 8'h00}, 16,
                 128'hF1_A0_A1_A2_A3_F2_B0_B1_F1_A4_A5_A6_A7_F1_A8_A9);
    vecs[3] = mk(50, {8'd1, 8'd1, 8'd1, 8'd1},  {8'h50, 8'h51, 8'h52, 8'h53}, 8,
                 64'hF0_50_F1_51_F2_52_F3_53);
    vecs[4] = mk(3,  {8'd1, 8'd0, 8'd0, 8'd5},  {8'h60, 8'h00, 8'h00, 8'h70}, 9,
                 72'hF0_60_F3_70_71_72_73_F3_74);
    vecs[5] = mk(1,  {8'd0, 8'd0, 8'd4, 8'd0},  {8'h00, 8'h00, 8'h80, 8'h00}, 5,
                 40'hF2_80_81_82_83);

    pause    = '0;
    hold_len = 3;
    for (int r = 0; r < 4; r++) wr[r] = 0;

    // reset values
    rst_begin();
    chk("rst_busy",   int'(bus.busy), 0);
    chk("rst_tx_req", int'(bus.tx_req), 0);
    chk("rst_tx_byte", int'(bus.tx_byte), 0);
    chk("rst_ready",  int'(bus.req_ready), 0);
    chk("rst_grant",  int'(bus.grant_id), 0);
    rst_end();
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_tx_req", int'(bus.tx_req), 0);

    // latency and back-to-back gap
    rst_begin();
    hold_len = 3;
    push(2, 1, 8'h77);
    rst_end();
    @(posedge clk); #1;
    chk("lat_busy",  int'(bus.busy), 1);
    chk("lat_grant", int'(bus.grant_id), 2);
    chk("lat_req_t1", int'(bus.tx_req), 0);
    chk("lat_ready_t1", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    chk("lat_req_t2", int'(bus.tx_req), 1);
    chk("lat_tag", int'(bus.tx_byte), 8'hF2);
    @(posedge clk); #1;
    chk("lat_req_t3", int'(bus.tx_req), 0);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.tx_idle && cyc < 20);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.tx_req && cyc < 20);
    chk("gap_cycles", cyc, 2);
    chk("gap_byte", int'(bus.tx_byte), 8'h77);
    wait_done("lat", 200);
    e = {8'hF2, 8'h77, 112'h0};
    check_wire("lat", e, 2);

    // table-driven message mixes
    for (int v = 0; v < 6; v++) begin
      rst_begin();
      hold_len = int'(vecs[v].hold);
      for (int r = 0; r < 4; r++)
        if (vecs[v].nb[r] != 0) push(r, int'(vecs[v].nb[r]), vecs[v].d0[r]);
      rst_end();
      wait_done($sformatf("v%0d", v), 4000);
      check_wire($sformatf("v%0d", v), vecs[v].exp, int'(vecs[v].len));
      for (int r = 0; r < 4; r++)
        chk($sformatf("v%0d_ready%0d", v, r), rdy_cnt[r], int'(vecs[v].nb[r]));
    end

    // idle timeout releases the grant mid-message
    rst_begin();
    hold_len = 3;
    push(1, 3, 8'hC0);
    rst_end();
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (rdy_cnt[1] != 1 && cyc < 100);
    pause[1] = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (bus.busy && cyc < 200);
    chk("tmo_released", int'(bus.busy), 0);
    chk("tmo_min", int'(cyc >= 20), 1);
    chk("tmo_max", int'(cyc <= 40), 1);
    chk("tmo_wire_len", wire_q.size(), 2);
    n0 = txreq_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("tmo_no_req", txreq_cnt, n0);
    chk("tmo_stays_arb", int'(bus.busy), 0);
    pause[1] = 1'b0;
    wait_done("tmo", 500);
    e = {40'hF1_C0_F1_C1_C2, 88'h0};
    check_wire("tmo", e, 5);

    // reset while waiting on the TX engine
    rst_begin();
    hold_len = 50;
    push(3, 2, 8'hD0);
    rst_end();
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (wire_q.size() < 2 && cyc < 300);
    repeat (10) @(posedge clk);
    chk("mid_grant", int'(bus.grant_id), 3);
    chk("mid_busy", int'(bus.busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   int'(bus.busy), 0);
    chk("arst_tx_req", int'(bus.tx_req), 0);
    chk("arst_tx_byte", int'(bus.tx_byte), 0);
    chk("arst_grant",  int'(bus.grant_id), 0);
    chk("arst_ready",  int'(bus.req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) wr[r] = 0;
    push(3, 2, 8'hD0);
    push(0, 1, 8'hE0);
    rst_end();
    wait_done("arst", 1000);
    e = {40'hF0_E0_F3_D0_D1, 88'h0};
    check_wire("arst", e, 5);

    chk("req_while_busy", req_while_busy, 0);
    chk("tx_byte_stable", unstable, 0);
    chk("ready_onehot", bad_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
